// File: rtl/brisc_sequencer.sv
// Fetch/decode/execute/writeback sequencer for a small 16-bit RISC core; 3 cycles per non-writing, 4 per writing instruction.
// Backpressure: instr_req holds in FETCH until instr_valid, so memory wait states stretch FETCH only.
module brisc_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   output logic        instr_req,
   output logic [7:0]  pc,
   input  logic        instr_valid,
   input  logic [15:0] instr_data,
   input  logic        alu_zero,
   output logic [3:0]  rd_addr,
   output logic [3:0]  rs_addr,
   output logic [7:0]  immediate,
   output logic [1:0]  imm_ctl,
   output logic [2:0]  alu_op,
   output logic        reg_we,
   output logic        illegal,
   output logic        halted
);

   typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, WRITEBACK, HALT} state_t;

   state_t      state;
   logic [15:0] ir;
   logic [3:0]  opcode;
   logic        is_write;
   logic        is_illegal;
   logic        take_jump;
   logic        fetch_ok;
   logic [1:0]  dec_ctl;
   logic [2:0]  dec_op;

   assign opcode     = ir[15:12];
   assign rd_addr    = ir[11:8];
   assign rs_addr    = ir[7:4];
   assign immediate  = ir[7:0];
   assign is_write   = (opcode >= 4'h1) && (opcode <= 4'h7);
   assign is_illegal = (opcode >= 4'hA) && (opcode != 4'hF);
   assign take_jump  = (opcode == 4'h8) || ((opcode == 4'h9) && alu_zero);

   // Gated by reset so the request drops the instant reset asserts, even with run high.
   assign instr_req  = (state == FETCH) && run && !reset;
   assign fetch_ok   = instr_req && instr_valid;

   // Decoded from the incoming word so the controls are already valid during DECODE.
   always_comb begin
      dec_ctl = 2'd0;
      dec_op  = 3'd0;
      case (instr_data[15:12])
         4'h1: dec_op = 3'd0;
         4'h2: dec_op = 3'd1;
         4'h3: dec_op = 3'd2;
         4'h4: dec_op = 3'd3;
         4'h5: begin dec_ctl = 2'd1; dec_op = 3'd0; end
         4'h6: begin dec_ctl = 2'd1; dec_op = 3'd5; end
         4'h7: begin dec_ctl = 2'd2; dec_op = 3'd5; end
         4'h9: dec_op = 3'd4;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= FETCH;
         pc      <= 8'h00;
         ir      <= 16'h0000;
         imm_ctl <= 2'd0;
         alu_op  <= 3'd0;
         reg_we  <= 1'b0;
         illegal <= 1'b0;
         halted  <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               if (fetch_ok) begin
                  ir      <= instr_data;
                  pc      <= pc + 8'd1;
                  imm_ctl <= dec_ctl;
                  alu_op  <= dec_op;
                  state   <= DECODE;
               end
            end
            DECODE: begin
               illegal <= is_illegal;
               state   <= EXECUTE;
            end
            EXECUTE: begin
               illegal <= 1'b0;
               if (take_jump)
                  pc <= immediate;
               if (is_write) begin
                  reg_we <= 1'b1;
                  state  <= WRITEBACK;
               end else begin
                  imm_ctl <= 2'd0;
                  alu_op  <= 3'd0;
                  if (opcode == 4'hF) begin
                     halted <= 1'b1;
                     state  <= HALT;
                  end else begin
                     state <= FETCH;
                  end
               end
            end
            WRITEBACK: begin
               // JAL keeps the return address on pc through this cycle for the register file.
               if (opcode == 4'h7)
                  pc <= immediate;
               reg_we  <= 1'b0;
               imm_ctl <= 2'd0;
               alu_op  <= 3'd0;
               state   <= FETCH;
            end
            HALT: state <= HALT;
            default: state <= FETCH;
         endcase
      end
   end

endmodule
